// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and address-field constants for the cache fill controller.
// Address layout: tag [15:10], set [9:4], word [3:1].
package cache_fill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    TAG,
    DONE
  } state_e;

  localparam int TAG_MSB  = 15;
  localparam int SET_MSB  = 9;
  localparam int SET_LSB  = 4;
  localparam int WORD_MSB = 3;
  localparam int WORD_LSB = 1;
  localparam int WORDS    = 8;
  localparam int SETS     = 64;

endpackage

// File: rtl/cache_fill_ctrl_onehot_dec.sv
// Index to one-hot decoder with an enable gate.
// Output is all-zero while the enable is low.
module onehot_dec
  import cache_fill_ctrl_pkg::*;
#(
  parameter int N = 3
) (
  input  logic            en_i,
  input  logic [N-1:0]    idx_i,
  output logic [2**N-1:0] oh_o
);

  localparam int M = 2**N;

  assign oh_o = en_i ? (M'(1) << idx_i) : '0;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler and LRU client for a 2-way, 64-set cache.
// Hits update LRU in-cycle; misses pick a victim and stream a block fill.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int WORDS   = 8,
  parameter int SETS    = 64,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              hit_valid,
  input  logic              hit_way,
  input  logic              miss_req,
  input  logic              lru_block0_isLRU,
  input  logic              lru_block1_isLRU,
  output logic [SETS-1:0]   lru_set_en,
  output logic              lru_write_en,
  output logic              lru_block,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  output logic              data_write,
  output logic              data_way,
  output logic [WORDS-1:0]  data_word_en,
  output logic              tag_write,
  output logic              tag_way,
  output logic              busy,
  output logic              fill_done
);

  localparam int SET_W = $clog2(SETS);
  localparam int WRD_W = $clog2(WORDS);
  localparam logic [3:0] CNT_MAX = 4'(WORDS);

  state_e                    state_q;
  logic [ADDR_W-1:SET_LSB]   line_q;
  logic                      victim_q;
  logic [3:0]                ic_q;
  logic [3:0]                rc_q;

  logic                      set_en;
  logic [SET_W-1:0]          set_idx;

  // Way 0 reporting LRU is implied whenever way 1 does not.
  logic unused_ok;
  assign unused_ok = ^{addr[SET_LSB-1:0], lru_block0_isLRU,
                       4'(MEM_LAT)};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      line_q   <= '0;
      victim_q <= 1'b0;
      ic_q     <= '0;
      rc_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ic_q <= '0;
          rc_q <= '0;
          if (miss_req) begin
            line_q  <= addr[ADDR_W-1:SET_LSB];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          victim_q <= lru_block1_isLRU;
          state_q  <= FILL;
        end
        FILL: begin
          if (ic_q < CNT_MAX) ic_q <= ic_q + 4'd1;
          if (mem_data_valid && rc_q < CNT_MAX) begin
            rc_q <= rc_q + 4'd1;
            if (rc_q == CNT_MAX - 4'd1) state_q <= TAG;
          end
        end
        TAG:     state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    set_en       = 1'b0;
    set_idx      = line_q[SET_MSB:SET_LSB];
    lru_write_en = 1'b0;
    lru_block    = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    data_write   = 1'b0;
    data_way     = 1'b0;
    tag_write    = 1'b0;
    tag_way      = 1'b0;
    busy         = 1'b1;
    fill_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy    = 1'b0;
        set_idx = addr[SET_MSB:SET_LSB];
        // A miss in the same cycle takes priority over the hit.
        if (rst && hit_valid && !miss_req) begin
          set_en       = 1'b1;
          lru_write_en = 1'b1;
          lru_block    = ~hit_way;
        end
      end
      LOOKUP: set_en = 1'b1;
      FILL: begin
        mem_rd = ic_q < CNT_MAX;
        if (mem_rd)
          mem_addr = {line_q, ic_q[WRD_W-1:0], 1'b0};
        data_write = mem_data_valid && rc_q < CNT_MAX;
        data_way   = data_write & victim_q;
      end
      TAG: begin
        tag_write    = 1'b1;
        tag_way      = victim_q;
        set_en       = 1'b1;
        lru_write_en = 1'b1;
        lru_block    = ~victim_q;
      end
      DONE:    fill_done = 1'b1;
      default: ;
    endcase
  end

  onehot_dec #(.N(SET_W)) u_set_dec (
    .en_i  (set_en),
    .idx_i (set_idx),
    .oh_o  (lru_set_en)
  );

  onehot_dec #(.N(WRD_W)) u_word_dec (
    .en_i  (data_write),
    .idx_i (rc_q[WRD_W-1:0]),
    .oh_o  (data_word_en)
  );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed misses/hits with a memory and LRU
// model; fill addresses and word enables are checked from a scoreboard.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        hit_valid;
  logic        hit_way;
  logic        miss_req;
  logic        lru_block0_isLRU;
  logic        lru_block1_isLRU;
  logic [63:0] lru_set_en;
  logic        lru_write_en;
  logic        lru_block;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic        data_write;
  logic        data_way;
  logic [7:0]  data_word_en;
  logic        tag_write;
  logic        tag_way;
  logic        busy;
  logic        fill_done;

  cache_fill_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .addr             (addr),
    .hit_valid        (hit_valid),
    .hit_way          (hit_way),
    .miss_req         (miss_req),
    .lru_block0_isLRU (lru_block0_isLRU),
    .lru_block1_isLRU (lru_block1_isLRU),
    .lru_set_en       (lru_set_en),
    .lru_write_en     (lru_write_en),
    .lru_block        (lru_block),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_data_valid   (mem_data_valid),
    .data_write       (data_write),
    .data_way         (data_way),
    .data_word_en     (data_word_en),
    .tag_write        (tag_write),
    .tag_way          (tag_way),
    .busy             (busy),
    .fill_done        (fill_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int illegal_seen = 0;

  logic [15:0] exp_addr[$];
  logic [7:0]  exp_wen[$];
  logic        exp_way[$];

  // Memory: fixed 4-cycle pipeline, plus forced stray pulses.
  logic [3:0] pipe = '0;
  logic       stray = 1'b0;
  assign mem_data_valid = pipe[3] | stray;

  // LRU array: bit set means way 1 is LRU; fresh sets report way 0.
  logic lru_mem [64] = '{default: 1'b0};
  logic blk1;

  always @(posedge clk) begin
    pipe <= {pipe[2:0], mem_rd};
    if (lru_write_en)
      for (int i = 0; i < 64; i++)
        if (lru_set_en[i]) lru_mem[i] <= lru_block;
  end

  always_comb begin
    blk1 = 1'b0;
    for (int i = 0; i < 64; i++)
      if (lru_set_en[i]) blk1 = lru_mem[i];
  end
  assign lru_block1_isLRU = blk1;
  assign lru_block0_isLRU = !blk1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd) begin
        if (exp_addr.size() == 0) chk("mem_rd_unexpected", mem_rd, 0);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (data_write) begin
        wr_cnt++;
        if (exp_wen.size() == 0) begin
          chk("data_write_unexpected", data_write, 0);
        end else begin
          chk("data_word_en", data_word_en, exp_wen.pop_front());
          chk("data_way", data_way, exp_way.pop_front());
        end
      end else if (data_word_en !== 8'h00) begin
        chk("data_word_en_idle", data_word_en, 0);
      end
      if (hit_valid && miss_req && !busy) begin
        illegal_seen++;
        $display("[TB] illegal hit+miss request seen at %0t", $time);
      end
    end
  end

  task automatic push_exp(input logic [15:0] a, input logic v);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] w;
      w = i[2:0];
      exp_addr.push_back({a[15:4], w, 1'b0});
      exp_wen.push_back(8'(1 << i));
      exp_way.push_back(v);
    end
  endtask

  task automatic run_miss(input logic [15:0] a, input logic v,
                          input logic both);
    int n;
    logic tag_seen;
    push_exp(a, v);
    @(posedge clk); #1;
    addr = a;
    miss_req = 1'b1;
    if (both) begin
      hit_valid = 1'b1;
      hit_way = 1'b0;
    end
    @(negedge clk);
    chk("miss_c0_busy", busy, 0);
    if (both) begin
      chk("both_lru_we", lru_write_en, 0);
      chk("both_set_en", lru_set_en, 0);
    end
    @(posedge clk); #1;
    hit_valid = 1'b0;
    addr = 16'hFFFF;
    @(negedge clk);
    miss_req = 1'b0;
    chk("lookup_busy", busy, 1);
    chk("lookup_set_en", lru_set_en, 64'(1) << a[9:4]);
    chk("lookup_lru_we", lru_write_en, 0);
    n = 1;
    tag_seen = 1'b0;
    while (!fill_done && n < 40) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
      if (tag_write) begin
        tag_seen = 1'b1;
        chk("tag_way", tag_way, v);
        chk("tag_lru_we", lru_write_en, 1);
        chk("tag_lru_block", lru_block, !v);
        chk("tag_set_en", lru_set_en, 64'(1) << a[9:4]);
      end
    end
    chk("fill_latency", n, 15);
    chk("tag_write_seen", tag_seen, 1);
    chk("done_busy", busy, 1);
    chk("done_set_en", lru_set_en, 0);
    chk("addr_q_drained", exp_addr.size(), 0);
    chk("wen_q_drained", exp_wen.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_done_busy", busy, 0);
    chk("post_done_pulse", fill_done, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    addr = '0;
    hit_valid = 1'b0;
    hit_way = 1'b0;
    miss_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_set_en", lru_set_en, 0);
    chk("rst_lru_we", lru_write_en, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_tag_write", tag_write, 0);

    @(posedge clk); #1;
    rst = 1'b1;
    miss_req = 1'b0;
    addr = 16'h0150;
    hit_valid = 1'b1;
    hit_way = 1'b1;
    @(negedge clk);
    chk("hit_set_en", lru_set_en, 64'(1) << 21);
    chk("hit_lru_we", lru_write_en, 1);
    chk("hit_lru_block", lru_block, 0);
    chk("hit_busy", busy, 0);
    @(posedge clk); #1;
    hit_valid = 1'b0;

    run_miss(16'hA4E6, 1'b0, 1'b0);
    run_miss(16'h7CE2, 1'b1, 1'b0);

    wr_cnt = 0;
    push_exp(16'h1230, 1'b0);
    @(posedge clk); #1;
    addr = 16'h1230;
    miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (wr_cnt < 3 && n < 40);
    #1;
    chk("rc3_reached", n < 40, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_addr.delete();
    exp_wen.delete();
    exp_way.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_set_en", lru_set_en, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      stray = (i % 2 == 0);
      @(negedge clk);
      chk("stray_data_write", data_write, 0);
      chk("stray_busy", busy, 0);
    end
    @(posedge clk); #1;
    stray = 1'b0;

    illegal_seen = 0;
    run_miss(16'h0150, 1'b0, 1'b1);
    chk("illegal_flagged", illegal_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss handler and LRU client for the 2-way, 64-set, 16-byte-block cache.
- Hit path: drives the LRU array write so the accessed way becomes MRU.
- Miss path: reads the LRU bits, picks the victim way, issues 8 pipelined word reads to memory, streams the returns into the data array, then writes the tag and updates LRU.
- Sits between the cache lookup logic, the LRU/data/tag arrays, and the pipelined main memory.

Parameters:
- ADDR_W, 16, byte address width.
- WORDS, 8, 16-bit words per block.
- SETS, 64, number of sets; set-enable width.
- MEM_LAT, 4, cycles from mem_rd to the matching mem_data_valid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- addr  in  16  access address: tag [15:10], set [9:4], word [3:1].
- hit_valid  in  1  lookup hit this cycle.
- hit_way  in  1  way that hit.
- miss_req  in  1  lookup miss this cycle, held until busy is seen.
- lru_block0_isLRU  in  1  LRU array output for the enabled set.
- lru_block1_isLRU  in  1  LRU array output for the enabled set.
- lru_set_en  out  64  one-hot set enable to the LRU array.
- lru_write_en  out  1  LRU write strobe.
- lru_block  out  1  way to mark as LRU.
- mem_rd  out  1  memory read issue.
- mem_addr  out  16  word-aligned read address.
- mem_data_valid  in  1  read data returned this cycle.
- data_write  out  1  data-array write strobe.
- data_way  out  1  way being filled.
- data_word_en  out  8  one-hot word select.
- tag_write  out  1  tag/valid write strobe.
- tag_way  out  1  way whose tag is written.
- busy  out  1  pipeline stall.
- fill_done  out  1  one-cycle pulse when the fill completes.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, counters=0.
  - All outputs 0, including lru_set_en=0.
  - Reset mid-fill abandons the fill; memory returns arriving in IDLE are ignored.
- LRU encoding: writing lru_block=b makes way b report LRU. For the used way u, drive lru_block = ~u.
- IDLE:
  - busy=0.
  - hit_valid=1: same cycle, lru_set_en=onehot(addr[9:4]), lru_write_en=1, lru_block=~hit_way. Stay in IDLE.
  - miss_req=1: latch addr, go to LOOKUP.
  - miss_req and hit_valid both 1: the miss wins and no LRU write occurs. This case is illegal; the bench asserts on it.
- LOOKUP (1 cycle):
  - busy=1; lru_set_en=onehot(latched set); lru_write_en=0.
  - victim = lru_block1_isLRU ? 1 : 0. An uninitialised set reports way0, so victim=0.
  - Latch victim, go to FILL.
- FILL:
  - busy=1.
  - Issue counter ic (0..8): while ic<8, mem_rd=1, mem_addr={tag,set,ic[2:0],1'b0}, ic++. One issue per cycle, so 8 consecutive cycles.
  - Receive counter rc (0..8): on mem_data_valid, data_write=1, data_way=victim, data_word_en=onehot(rc), rc++.
  - Returns are in order; the first arrives MEM_LAT cycles after the first issue.
  - mem_data_valid while rc==8 is ignored.
  - Leave FILL the cycle after rc reaches 8. Nominal FILL duration is MEM_LAT+8 cycles.
- TAG (1 cycle):
  - tag_write=1, tag_way=victim.
  - lru_set_en=onehot(set), lru_write_en=1, lru_block=~victim.
  - Go to DONE.
- DONE (1 cycle): fill_done=1, busy=1. Go to IDLE; busy drops the following cycle.
- During LOOKUP/FILL/TAG/DONE, hit_valid and miss_req are ignored.
- Latency from miss_req to fill_done (MEM_LAT=4): 1+12+1+1 = 15 cycles.
- Width rules:
  - ic and rc are 4 bits and saturate at 8.
  - data_word_en is 0 whenever data_write=0.
  - lru_set_en is 0 in FILL and DONE.

Decomposition:
- Shared package holds:
  - state enum {IDLE, LOOKUP, FILL, TAG, DONE};
  - address field constants TAG_MSB=15, SET_MSB=9, SET_LSB=4, WORD_MSB=3, WORD_LSB=1;
  - WORDS and SETS.
- One sub-module: onehot_dec (N-bit index to 2^N one-hot, enable gated), instanced for lru_set_en (6 to 64) and data_word_en (3 to 8).

Test Plan:
- Reset: rst=0 for 2 cycles with miss_req=1 -> busy=0, mem_rd=0, lru_set_en=0, state IDLE.
- Hit update: hit_valid=1, addr=0x0150, hit_way=1 -> same cycle lru_set_en=1<<21, lru_write_en=1, lru_block=0, busy=0.
- Cold miss: addr=0xA4E6 on a fresh set -> victim=0. mem_rd for 8 cycles at addresses 0xA4E0 through 0xA4EE. data_word_en walks 0x01 to 0x80. Then tag_write (tag_way=0) with lru_block=1, and fill_done 15 cycles after miss_req.
- Second miss to the same set after way0 is filled -> victim=1, tag_way=1, final lru_block=0.
- Reset asserted mid-FILL with rc=3 -> next cycle IDLE, busy=0. Subsequent stray mem_data_valid pulses produce no data_write.
- Simultaneous hit_valid=1 and miss_req=1 -> miss taken, lru_write_en=0 in that cycle, assertion fires.
